// File: rtl/cpu_line_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_line_mem_ctrl_if
// Purpose: bundles the CPU cache-line port and the host memory bus seen by
//          cpu_line_mem_ctrl.
// Modports:
//   slave  - the line controller. It takes the CPU request and the host
//            responses, and drives the CPU results and the host command/beats.
//   master - the environment (the cache plus the host memory). Signal
//            directions are the reverse of slave.
// Signals:
//   op_cpu, AddrIn_cpu, DataIn_cpu          CPU request
//   DataOut_cpu, tx_done_cpu, rd_valid_cpu  CPU completion
//   busy                                    controller not idle
//   mem_cmd_valid/ready/we/addr             host command handshake
//   mem_wdata/wvalid/wready                 host write beats
//   mem_rdata/rvalid                        host read beats (no backpressure)
// ---------------------------------------------------------------------------
interface cpu_line_mem_ctrl_if #(
    parameter int unsigned CL_SIZE_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned BEAT_WIDTH    = 64
);
    logic [1:0]               op_cpu;
    logic [ADDR_WIDTH-1:0]    AddrIn_cpu;
    logic [CL_SIZE_WIDTH-1:0] DataIn_cpu;
    logic [CL_SIZE_WIDTH-1:0] DataOut_cpu;
    logic                     tx_done_cpu;
    logic                     rd_valid_cpu;
    logic                     busy;
    logic                     mem_cmd_valid;
    logic                     mem_cmd_ready;
    logic                     mem_cmd_we;
    logic [ADDR_WIDTH-1:0]    mem_cmd_addr;
    logic [BEAT_WIDTH-1:0]    mem_wdata;
    logic                     mem_wvalid;
    logic                     mem_wready;
    logic [BEAT_WIDTH-1:0]    mem_rdata;
    logic                     mem_rvalid;

    modport slave (
        input  op_cpu, AddrIn_cpu, DataIn_cpu,
        input  mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
        output DataOut_cpu, tx_done_cpu, rd_valid_cpu, busy,
        output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid
    );

    modport master (
        output op_cpu, AddrIn_cpu, DataIn_cpu,
        output mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
        input  DataOut_cpu, tx_done_cpu, rd_valid_cpu, busy,
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid
    );
endinterface

// File: rtl/cpu_line_mem_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_line_mem_ctrl
// Purpose: responder for whole-line CPU cache requests. Each read (op=01) or
//          write-back (op=11) becomes one host command followed by
//          CL_SIZE_WIDTH/BEAT_WIDTH data beats. A one-cycle done pulse goes
//          back to the cache when the request completes.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous reset, active low
//   bus    - cpu_line_mem_ctrl_if.slave (CPU request/response + host bus)
// ---------------------------------------------------------------------------
module cpu_line_mem_ctrl #(
    parameter int unsigned          CL_SIZE_WIDTH  = 512,
    parameter int unsigned          ADDR_WIDTH     = 32,
    parameter int unsigned          BEAT_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] HOST_BASE_ADDR = '0
) (
    input logic                clk,
    input logic                rst_n,
    cpu_line_mem_ctrl_if.slave bus
);
    localparam int unsigned BEATS = CL_SIZE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(CL_SIZE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the byte-within-line offset bits of the CPU address.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWbeat,
        StRbeat,
        StDone,
        StCool
    } state_e;

    state_e                   r_state;
    state_e                   w_state_d;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_d;
    logic                     r_we;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [CL_SIZE_WIDTH-1:0] r_wline;
    logic [CL_SIZE_WIDTH-1:0] r_rline;
    logic [CL_SIZE_WIDTH-1:0] r_dout;
    logic [CL_SIZE_WIDTH-1:0] w_rline_d;
    logic [BEAT_WIDTH-1:0]    w_wbeat;
    logic                     w_accept;
    logic                     w_rstore;
    logic                     w_rlast;

    // Beat select for the outgoing write data, and the line buffer with the
    // incoming read beat merged in at the current count.
    always_comb begin
        w_wbeat   = '0;
        w_rline_d = r_rline;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                w_wbeat                              = r_wline[b*BEAT_WIDTH +: BEAT_WIDTH];
                w_rline_d[b*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_accept  = 1'b0;
        w_rstore  = 1'b0;
        w_rlast   = 1'b0;
        case (r_state)
            StIdle: begin
                if ((bus.op_cpu == 2'b01) || (bus.op_cpu == 2'b11)) begin
                    w_accept  = 1'b1;
                    w_state_d = StCmd;
                end
            end
            StCmd: begin
                if (bus.mem_cmd_ready) begin
                    w_cnt_d   = '0;
                    w_state_d = r_we ? StWbeat : StRbeat;
                end
            end
            StWbeat: begin
                if (bus.mem_wready) begin
                    if (r_cnt == LAST_BEAT) begin
                        w_state_d = StDone;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StRbeat: begin
                if (bus.mem_rvalid) begin
                    w_rstore = 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_rlast   = 1'b1;
                        w_state_d = StDone;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StDone:  w_state_d = StCool;
            // Swallows the op the cache still holds during the done cycle.
            StCool:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rline <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_we    <= bus.op_cpu[1];
                r_addr  <= (bus.AddrIn_cpu & LINE_MASK) + HOST_BASE_ADDR;
                r_wline <= bus.DataIn_cpu;
            end
            if (w_rstore) begin
                r_rline <= w_rline_d;
            end
            // The result register is loaded with the completed line so it is
            // presented together with the done pulse and held until the next read.
            if (w_rlast) begin
                r_dout <= w_rline_d;
            end
        end
    end

    assign bus.busy          = (r_state != StIdle);
    assign bus.mem_cmd_valid = (r_state == StCmd);
    assign bus.mem_cmd_we    = r_we;
    assign bus.mem_cmd_addr  = r_addr;
    assign bus.mem_wvalid    = (r_state == StWbeat);
    assign bus.mem_wdata     = w_wbeat;
    assign bus.tx_done_cpu   = (r_state == StDone);
    assign bus.rd_valid_cpu  = (r_state == StDone) && !r_we;
    assign bus.DataOut_cpu   = r_dout;
endmodule

// File: tb/tb_cpu_line_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_line_mem_ctrl
// Purpose: self-checking bench for cpu_line_mem_ctrl. The bench plays both
//          the cache and the host memory. Expected host commands, write beats
//          and returned lines come from a simple line/beat model.
// ---------------------------------------------------------------------------
module tb_cpu_line_mem_ctrl;
    localparam int unsigned CL    = 512;
    localparam int unsigned AW    = 32;
    localparam int unsigned BW    = 64;
    localparam int unsigned BEATS = CL / BW;
    localparam logic [AW-1:0] BASE = 32'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [CL-1:0] prev_dout = '0;

    cpu_line_mem_ctrl_if #(
        .CL_SIZE_WIDTH(CL),
        .ADDR_WIDTH   (AW),
        .BEAT_WIDTH   (BW)
    ) u_bus ();

    cpu_line_mem_ctrl #(
        .CL_SIZE_WIDTH (CL),
        .ADDR_WIDTH    (AW),
        .BEAT_WIDTH    (BW),
        .HOST_BASE_ADDR(BASE)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [CL-1:0] rand_line();
        logic [CL-1:0] l;
        for (int i = 0; i < CL / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Host address: CPU address rounded down to a 64-byte line, plus base, mod 2^AW.
    function automatic logic [AW-1:0] host_addr(input logic [AW-1:0] a);
        longint unsigned v;
        v = ((longint'(a) / 64) * 64 + longint'(BASE)) % (64'd1 << AW);
        return v[AW-1:0];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, CL'({u_bus.tx_done_cpu, u_bus.rd_valid_cpu, u_bus.busy,
                               u_bus.mem_cmd_valid, u_bus.mem_cmd_we, u_bus.mem_wvalid}), '0);
        chk({tag, "_addr"}, CL'(u_bus.mem_cmd_addr), '0);
        chk({tag, "_wdata"}, CL'(u_bus.mem_wdata), '0);
        chk({tag, "_dout"}, u_bus.DataOut_cpu, '0);
    endtask

    // One full request as seen from both sides. Entered and left at a sample
    // point with the controller idle.
    task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [CL-1:0] line, input int stall_cmd,
                           input bit wr_toggle, input int gap_pct, input bit noise,
                           input bit fixed_rd, input bit hold, input logic [1:0] next_op,
                           input bit check_lat);
        bit            is_rd;
        bit            cmd_done;
        bit            done;
        int            n_cmds;
        int            wbeats;
        int            rgiven;
        int            c;
        logic [AW-1:0] exp_addr;
        logic [CL-1:0] exp_line;
        logic [BW-1:0] beat;
        is_rd    = (op == 2'b01);
        exp_addr = host_addr(addr);
        exp_line = '0;
        cmd_done = 1'b0;
        done     = 1'b0;
        n_cmds   = 0;
        wbeats   = 0;
        rgiven   = 0;
        chk("idle_before", CL'(u_bus.busy), CL'(1'b0));
        u_bus.op_cpu     = op;
        u_bus.AddrIn_cpu = addr;
        u_bus.DataIn_cpu = line;
        u_bus.mem_rvalid = noise;   // stray beat while idle
        u_bus.mem_rdata  = rand64();
        tick();
        c = 1;
        chk("accept_busy", CL'(u_bus.busy), CL'(1'b1));
        while (!done && c < 300) begin
            if (u_bus.tx_done_cpu) begin
                done = 1'b1;
            end else begin
                if (!cmd_done) begin
                    chk("cmd_valid", CL'(u_bus.mem_cmd_valid), CL'(1'b1));
                    chk("cmd_addr", CL'(u_bus.mem_cmd_addr), CL'(exp_addr));
                    chk("cmd_we", CL'(u_bus.mem_cmd_we), CL'(!is_rd));
                end else begin
                    chk("cmd_valid_drop", CL'(u_bus.mem_cmd_valid), CL'(1'b0));
                end
                if (!hold) begin
                    u_bus.op_cpu     = 2'($urandom);
                    u_bus.AddrIn_cpu = $urandom;
                    u_bus.DataIn_cpu = rand_line();
                end
                u_bus.mem_cmd_ready = (c > stall_cmd);
                if (u_bus.mem_cmd_valid && u_bus.mem_cmd_ready) n_cmds++;
                u_bus.mem_wready = wr_toggle ? c[0] : 1'b1;
                if (u_bus.mem_wvalid && u_bus.mem_wready) begin
                    chk("wdata", CL'(u_bus.mem_wdata), CL'(line[wbeats*BW +: BW]));
                    wbeats++;
                end
                u_bus.mem_rvalid = 1'b0;
                u_bus.mem_rdata  = rand64();
                if (is_rd && cmd_done && rgiven < int'(BEATS)) begin
                    if ($urandom_range(99) >= gap_pct) begin
                        beat = fixed_rd ? 64'hA0 + 64'(rgiven) : rand64();
                        u_bus.mem_rvalid = 1'b1;
                        u_bus.mem_rdata  = beat;
                        exp_line[rgiven*BW +: BW] = beat;
                        rgiven++;
                    end
                end else if (noise && (!cmd_done || !is_rd)) begin
                    u_bus.mem_rvalid = 1'($urandom_range(1));
                end
                if (u_bus.mem_cmd_valid && u_bus.mem_cmd_ready) cmd_done = 1'b1;
                tick();
                c++;
            end
        end
        chk("done_seen", CL'(done), CL'(1'b1));
        if (done) begin
            if (check_lat) chk("latency", CL'(c), CL'(10));
            chk("n_cmds", CL'(n_cmds), CL'(1));
            chk("rd_valid", CL'(u_bus.rd_valid_cpu), CL'(is_rd));
            if (is_rd) begin
                chk("rbeats", CL'(rgiven), CL'(BEATS));
                prev_dout = exp_line;
            end else begin
                chk("wbeats", CL'(wbeats), CL'(BEATS));
            end
            chk("dout", u_bus.DataOut_cpu, prev_dout);
        end
        // Done cycle: the cache still holds its op (or noise) here.
        u_bus.mem_rvalid = 1'b0;
        u_bus.mem_wready = 1'b0;
        if (!hold) u_bus.op_cpu = 2'($urandom);
        tick();
        chk("cool_done", CL'(u_bus.tx_done_cpu), CL'(1'b0));
        chk("cool_rdv", CL'(u_bus.rd_valid_cpu), CL'(1'b0));
        chk("cool_busy", CL'(u_bus.busy), CL'(1'b1));
        u_bus.op_cpu = next_op;
        tick();
        chk("back_idle", CL'(u_bus.busy), CL'(1'b0));
        chk("idle_cmd", CL'(u_bus.mem_cmd_valid), CL'(1'b0));
        chk("dout_hold", u_bus.DataOut_cpu, prev_dout);
    endtask

    initial begin
        logic [CL-1:0] line;
        logic [1:0]    op;
        int            stall;
        int            gap;
        bit            tog;
        bit            noise;

        u_bus.op_cpu        = 2'b00;
        u_bus.AddrIn_cpu    = '0;
        u_bus.DataIn_cpu    = '0;
        u_bus.mem_cmd_ready = 1'b0;
        u_bus.mem_wready    = 1'b0;
        u_bus.mem_rdata     = '0;
        u_bus.mem_rvalid    = 1'b0;

        // Power-on reset.
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        // Directed read, always-ready host, rdata beat i = A0+i.
        run_txn(2'b01, 32'h0000_1234, '0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);

        // Directed write, wready toggling, beats 11..88.
        for (int i = 0; i < int'(BEATS); i++) line[i*BW +: BW] = 64'h11 * 64'(i + 1);
        run_txn(2'b11, 32'h0000_4040, line, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Directed write, always-ready host: minimum latency.
        run_txn(2'b11, $urandom, rand_line(), 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        // Back-to-back write-back then read, op held through done.
        run_txn(2'b11, 32'h0000_2000, rand_line(), 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        run_txn(2'b01, 32'h0000_3000, '0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Command stall, read gaps and stray read beats.
        run_txn(2'b01, $urandom, '0, 5, 1'b0, 40, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        run_txn(2'b11, $urandom, rand_line(), 5, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // Reserved op must not start anything.
        u_bus.op_cpu     = 2'b10;
        u_bus.AddrIn_cpu = $urandom;
        repeat (6) begin
            tick();
            chk("rsv_busy", CL'(u_bus.busy), CL'(1'b0));
            chk("rsv_cmd", CL'(u_bus.mem_cmd_valid), CL'(1'b0));
        end
        u_bus.op_cpu = 2'b00;

        // Random requests with random host timing.
        for (int n = 0; n < 12; n++) begin
            op    = ($urandom_range(1) == 1) ? 2'b11 : 2'b01;
            line  = rand_line();
            stall = $urandom_range(3);
            tog   = 1'($urandom_range(1));
            gap   = $urandom_range(50);
            noise = 1'($urandom_range(1));
            run_txn(op, $urandom, line, stall, tog, gap, noise, 1'b0, 1'b0, 2'b00, 1'b0);
        end

        // Reset in the middle of a read burst.
        u_bus.op_cpu        = 2'b01;
        u_bus.AddrIn_cpu    = $urandom;
        tick();
        u_bus.op_cpu        = 2'b00;
        u_bus.mem_cmd_ready = 1'b1;
        tick();
        u_bus.mem_rvalid = 1'b1;
        repeat (3) begin
            u_bus.mem_rdata = rand64();
            tick();
        end
        u_bus.mem_rvalid = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("mid_rst");
        rst_n     = 1'b1;
        prev_dout = '0;
        tick();
        run_txn(2'b01, 32'h0000_5678, '0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
